mac_dot_sequencer: RTL

//  Initiator side of the MAC-unit handshake: computes a dot product of vec_len operand pairs.

---
 rtl/mac_dot_sequencer_if.sv | 42 ++++
 rtl/mac_dot_sequencer.sv | 134 +++++++++++++
 2 files changed

// File: rtl/mac_dot_sequencer_if.sv
// Bundle of every handshake between the dot-product sequencer, its operand source,
// the MAC unit it drives and the consumer of the finished sum.
interface mac_dot_sequencer_if #(
   parameter int DATA_WIDTH = 8,
   parameter int ACC_WIDTH  = 32,
   parameter int LEN_WIDTH  = 8
);
   logic                  start;
   logic [LEN_WIDTH-1:0]  vec_len;
   logic                  busy;

   logic                  in_valid;
   logic                  in_ready;
   logic [DATA_WIDTH-1:0] in_a;
   logic [DATA_WIDTH-1:0] in_b;

   logic [DATA_WIDTH-1:0] mac_operand_a;
   logic [DATA_WIDTH-1:0] mac_operand_b;
   logic [ACC_WIDTH-1:0]  mac_acc_in;
   logic                  mac_valid;
   logic                  mac_rst_acc;
   logic [ACC_WIDTH-1:0]  mac_acc_out;
   logic                  mac_done;

   logic                  res_valid;
   logic                  res_ready;
   logic [ACC_WIDTH-1:0]  res_data;
   logic                  res_err;

   // master is the sequencer itself; slave is everything around it
   modport master (
      input  start, vec_len, in_valid, in_a, in_b, mac_acc_out, mac_done, res_ready,
      output busy, in_ready, mac_operand_a, mac_operand_b, mac_acc_in,
             mac_valid, mac_rst_acc, res_valid, res_data, res_err
   );

   modport slave (
      output start, vec_len, in_valid, in_a, in_b, mac_acc_out, mac_done, res_ready,
      input  busy, in_ready, mac_operand_a, mac_operand_b, mac_acc_in,
             mac_valid, mac_rst_acc, res_valid, res_data, res_err
   );
endinterface

// File: rtl/mac_dot_sequencer.sv
// Dot-product sequencer: streams operand pairs into a single MAC unit one at a time,
// threads the returned accumulator back in, and presents the final (or partial) sum.
module mac_dot_sequencer #(
   parameter int DATA_WIDTH = 8,
   parameter int ACC_WIDTH  = 32,
   parameter int LEN_WIDTH  = 8,
   parameter int TIMEOUT    = 16
) (
   input logic                clk,
   input logic                rst_n,
   mac_dot_sequencer_if.master seq_if
);

   localparam int TIMER_WIDTH = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [TIMER_WIDTH-1:0] TIMER_LAST = TIMER_WIDTH'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      ISSUE,
      WAIT,
      OUT
   } state_e;

   state_e                 state_q, state_d;
   logic [LEN_WIDTH-1:0]   len_q, len_d;
   logic [LEN_WIDTH-1:0]   count_q, count_d;
   logic [LEN_WIDTH-1:0]   count_inc;
   logic [TIMER_WIDTH-1:0] timer_q, timer_d;
   logic [DATA_WIDTH-1:0]  op_a_q, op_a_d;
   logic [DATA_WIDTH-1:0]  op_b_q, op_b_d;
   logic [ACC_WIDTH-1:0]   acc_q, acc_d;
   logic                   err_q, err_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         len_q   <= '0;
         count_q <= '0;
         timer_q <= '0;
         op_a_q  <= '0;
         op_b_q  <= '0;
         acc_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         count_q <= count_d;
         timer_q <= timer_d;
         op_a_q  <= op_a_d;
         op_b_q  <= op_b_d;
         acc_q   <= acc_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      len_d     = len_q;
      count_d   = count_q;
      timer_d   = timer_q;
      op_a_d    = op_a_q;
      op_b_d    = op_b_q;
      acc_d     = acc_q;
      err_d     = err_q;
      count_inc = count_q + LEN_WIDTH'(1);

      case (state_q)
         IDLE: begin
            if (seq_if.start) begin
               acc_d = '0;
               err_d = 1'b0;
               if (seq_if.vec_len != '0) begin
                  len_d   = seq_if.vec_len;
                  count_d = '0;
                  state_d = FETCH;
               end else begin
                  state_d = OUT;
               end
            end
         end

         FETCH: begin
            if (seq_if.in_valid) begin
               op_a_d  = seq_if.in_a;
               op_b_d  = seq_if.in_b;
               state_d = ISSUE;
            end
         end

         ISSUE: begin
            timer_d = '0;
            state_d = WAIT;
         end

         // A completion arriving on the timeout cycle still counts as a good result
         WAIT: begin
            if (seq_if.mac_done) begin
               acc_d   = seq_if.mac_acc_out;
               count_d = count_inc;
               state_d = (count_inc == len_q) ? OUT : FETCH;
            end else if (timer_q == TIMER_LAST) begin
               err_d   = 1'b1;
               state_d = OUT;
            end else begin
               timer_d = timer_q + TIMER_WIDTH'(1);
            end
         end

         OUT: begin
            if (seq_if.res_ready) begin
               state_d = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Operands and running sum come straight from registers so they stay put through WAIT
   assign seq_if.busy          = (state_q != IDLE);
   assign seq_if.in_ready      = (state_q == FETCH);
   assign seq_if.mac_valid     = (state_q == ISSUE);
   assign seq_if.mac_rst_acc   = (state_q == ISSUE) && (count_q == '0);
   assign seq_if.mac_operand_a = op_a_q;
   assign seq_if.mac_operand_b = op_b_q;
   assign seq_if.mac_acc_in    = acc_q;
   assign seq_if.res_valid     = (state_q == OUT);
   assign seq_if.res_data      = acc_q;
   assign seq_if.res_err       = err_q;

endmodule
